// File: rtl/core_boot_pkg.sv
// Shared types and default widths for the boot controller and the processor's IMEM.
package core_boot_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned CYC_W      = 16;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } boot_state_e;

endpackage

// File: rtl/boot_run_timer.sv
// Reset-hold down-counter and saturating run-cycle counter for the boot controller.
module boot_run_timer
    import core_boot_pkg::*;
#(
    parameter int unsigned RST_HOLD  = 4,
    parameter int unsigned RUN_LIMIT = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_hold_load,
    input  logic             i_hold_en,
    input  logic             i_run_en,
    output logic             o_hold_done_c,
    output logic             o_run_limit_c,
    output logic [CYC_W-1:0] o_cycle_count
);

    localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    logic [HOLD_W-1:0] r_hold_cnt;
    logic [CYC_W-1:0]  r_cycle_cnt;

    // Loaded with RST_HOLD-1 so the HOLD state lasts exactly RST_HOLD cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt <= '0;
        end else if (i_hold_load) begin
            r_hold_cnt <= HOLD_W'(RST_HOLD - 1);
        end else if (i_hold_en && (r_hold_cnt != '0)) begin
            r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_cnt <= '0;
        end else if (i_run_en && (r_cycle_cnt != '1)) begin
            r_cycle_cnt <= r_cycle_cnt + CYC_W'(1);
        end
    end

    assign o_hold_done_c = (r_hold_cnt == '0);
    assign o_run_limit_c = (r_cycle_cnt == CYC_W'(RUN_LIMIT - 1));
    assign o_cycle_count = r_cycle_cnt;

endmodule

// File: rtl/core_boot_ctrl.sv
// Loads a program image into IMEM, then sequences the core's reset, run window and termination.
module core_boot_ctrl
    import core_boot_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned RST_HOLD  = 4,
    parameter int unsigned RUN_LIMIT = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_rst,
    input  logic              core_halt,
    output logic              running,
    output logic              done,
    output logic              timeout,
    output logic [CYC_W-1:0]  cycle_count,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned WL_W = ADDR_W + 1;

    boot_state_e       r_state;
    boot_state_e       w_state_nxt;
    logic [ADDR_W-1:0] w_ptr;
    logic              w_xfer;
    logic              w_hold_load;
    logic              w_hold_en;
    logic              w_run_en;
    logic              w_timeout_set;
    logic              w_hold_done;
    logic              w_run_limit;

    // The low bits of the accepted-word count double as the IMEM write pointer.
    assign w_ptr = words_loaded[ADDR_W-1:0];

    boot_run_timer #(
        .RST_HOLD  (RST_HOLD),
        .RUN_LIMIT (RUN_LIMIT)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .i_hold_load   (w_hold_load),
        .i_hold_en     (w_hold_en),
        .i_run_en      (w_run_en),
        .o_hold_done_c (w_hold_done),
        .o_run_limit_c (w_run_limit),
        .o_cycle_count (cycle_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_xfer        = 1'b0;
        w_hold_load   = 1'b0;
        w_hold_en     = 1'b0;
        w_run_en      = 1'b0;
        w_timeout_set = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_xfer = in_valid & in_ready;
                // The top address ends the image even without in_last; no wrap.
                if (w_xfer && (in_last || (w_ptr == '1))) begin
                    w_state_nxt = ST_HOLD;
                    w_hold_load = 1'b1;
                end
            end
            ST_HOLD: begin
                w_hold_en = 1'b1;
                if (w_hold_done) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (core_halt) begin
                    w_state_nxt = ST_DONE;
                end else if (w_run_limit) begin
                    w_state_nxt   = ST_DONE;
                    w_timeout_set = 1'b1;
                end else begin
                    w_run_en = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_LOAD;
            end
        endcase
    end

    // Status outputs follow the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready <= 1'b1;
            core_rst <= 1'b1;
            running  <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            in_ready <= (w_state_nxt == ST_LOAD);
            core_rst <= (w_state_nxt != ST_RUN);
            running  <= (w_state_nxt == ST_RUN);
            done     <= (w_state_nxt == ST_DONE);
            if (w_timeout_set) begin
                timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            words_loaded <= '0;
        end else begin
            imem_we <= w_xfer;
            if (w_xfer) begin
                imem_addr    <= w_ptr;
                imem_wdata   <= in_data;
                words_loaded <= words_loaded + WL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_core_boot_ctrl.sv
// Directed bench for core_boot_ctrl: IMEM write scoreboard plus reset/hold/run/limit checks.
module tb_core_boot_ctrl;

    localparam int RUN_LIMIT = 20;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_last, core_halt;
    logic [31:0] in_data;
    logic        in_ready, imem_we, core_rst, running, done, timeout;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [15:0] cycle_count;
    logic [8:0]  words_loaded;

    logic        b_rst, b_in_valid, b_in_last, b_core_halt;
    logic [31:0] b_in_data;
    logic        b_in_ready, b_imem_we, b_core_rst, b_running, b_done, b_timeout;
    logic [1:0]  b_imem_addr;
    logic [31:0] b_imem_wdata;
    logic [15:0] b_cycle_count;
    logic [2:0]  b_words_loaded;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];
    int  model_ptr = 0;

    always #5 clk = ~clk;

    core_boot_ctrl #(.ADDR_W(8), .DATA_W(32), .RST_HOLD(4), .RUN_LIMIT(RUN_LIMIT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst(core_rst), .core_halt(core_halt), .running(running), .done(done),
        .timeout(timeout), .cycle_count(cycle_count), .words_loaded(words_loaded)
    );

    core_boot_ctrl #(.ADDR_W(2), .DATA_W(32), .RST_HOLD(4), .RUN_LIMIT(RUN_LIMIT)) dut_small (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_data(b_in_data), .in_last(b_in_last),
        .in_ready(b_in_ready), .imem_we(b_imem_we), .imem_addr(b_imem_addr), .imem_wdata(b_imem_wdata),
        .core_rst(b_core_rst), .core_halt(b_core_halt), .running(b_running), .done(b_done),
        .timeout(b_timeout), .cycle_count(b_cycle_count), .words_loaded(b_words_loaded)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every IMEM write must match the oldest expected transfer.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("we_unexpected", 32'(imem_we), 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(imem_addr), 32'(e.addr));
                chk("wr_data", imem_wdata, e.data);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        core_halt = 1'b0;
        tick();
        rst       = 1'b0;
        model_ptr = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_core_rst"}, 32'(core_rst), 32'd1);
        chk({tag, "_imem_we"}, 32'(imem_we), 32'd0);
        chk({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, "_imem_wdata"}, imem_wdata, 32'd0);
        chk({tag, "_running"}, 32'(running), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
        chk({tag, "_cycle_count"}, 32'(cycle_count), 32'd0);
        chk({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    // Drives one word for a single cycle; the caller decides what follows.
    task automatic send_word(input logic [31:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        exp_q.push_back({8'(model_ptr), d});
        model_ptr++;
        tick();
    endtask

    task automatic load_one(input logic [31:0] d);
        send_word(d, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (4) tick();
    endtask

    // Entered on the negedge of RUN cycle 0; halt_at >= RUN_LIMIT means never halt.
    task automatic run_check(input string tag, input int halt_at);
        int exp_cnt;
        exp_cnt = (halt_at < RUN_LIMIT) ? halt_at : RUN_LIMIT - 1;
        for (int i = 0; i < RUN_LIMIT; i++) begin
            chk({tag, "_cnt"}, 32'(cycle_count), 32'(i));
            chk({tag, "_running"}, 32'(running), 32'd1);
            chk({tag, "_core_rst_low"}, 32'(core_rst), 32'd0);
            core_halt = (i == halt_at);
            tick();
            if (i == exp_cnt) break;
        end
        core_halt = 1'b0;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_timeout"}, 32'(timeout), 32'(halt_at >= RUN_LIMIT));
        chk({tag, "_final_cnt"}, 32'(cycle_count), 32'(exp_cnt));
        chk({tag, "_core_rst_hi"}, 32'(core_rst), 32'd1);
        chk({tag, "_running_lo"}, 32'(running), 32'd0);
        repeat (3) tick();
        chk({tag, "_frozen_cnt"}, 32'(cycle_count), 32'(exp_cnt));
        chk({tag, "_done_sticky"}, 32'(done), 32'd1);
    endtask

    initial begin
        in_data     = 32'd0;
        b_rst       = 1'b1;
        b_in_valid  = 1'b0;
        b_in_last   = 1'b0;
        b_in_data   = 32'd0;
        b_core_halt = 1'b0;
        do_reset();
        chk_reset_vals("rst0");

        // Three-word image, then a held valid that must not be accepted.
        send_word(32'h11, 1'b0);
        send_word(32'h22, 1'b0);
        send_word(32'h33, 1'b1);
        in_valid  = 1'b1;
        in_data   = 32'hDEAD;
        in_last   = 1'b0;
        core_halt = 1'b1;
        chk("img3_in_ready", 32'(in_ready), 32'd0);
        chk("img3_words", 32'(words_loaded), 32'd3);
        chk("img3_core_rst", 32'(core_rst), 32'd1);
        chk("img3_running", 32'(running), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_core_rst", 32'(core_rst), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_running", 32'(running), 32'd0);
        end
        tick();
        in_valid = 1'b0;
        run_check("timeout", 99);
        chk("img3_words_end", 32'(words_loaded), 32'd3);

        do_reset();
        chk_reset_vals("rst1");
        load_one(32'h55);
        run_check("halt5", 5);

        do_reset();
        load_one(32'h66);
        run_check("halt19", 19);

        do_reset();
        load_one(32'h77);
        run_check("halt0", 0);

        // Reset mid-load, reload from address 0, then reset mid-run.
        do_reset();
        send_word(32'hA1, 1'b0);
        send_word(32'hA2, 1'b0);
        do_reset();
        chk_reset_vals("midload");
        send_word(32'hB1, 1'b1);
        in_valid = 1'b0;
        chk("reload_words", 32'(words_loaded), 32'd1);
        repeat (4) tick();
        chk("reload_running", 32'(running), 32'd1);
        repeat (3) tick();
        chk("reload_cnt", 32'(cycle_count), 32'd3);
        do_reset();
        chk_reset_vals("midrun");

        // Gapped stream, in_last without valid, halt pulses while loading.
        core_halt = 1'b1;
        send_word(32'hC1, 1'b0);
        in_valid = 1'b0;
        in_last  = 1'b1;
        repeat (2) tick();
        in_last = 1'b0;
        chk("gap_words", 32'(words_loaded), 32'd1);
        chk("gap_in_ready", 32'(in_ready), 32'd1);
        send_word(32'hC2, 1'b0);
        in_valid = 1'b0;
        tick();
        send_word(32'hC3, 1'b1);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        chk("gap_words_end", 32'(words_loaded), 32'd3);
        chk("gap_in_ready_end", 32'(in_ready), 32'd0);
        chk("gap_done_lo", 32'(done), 32'd0);
        repeat (4) tick();
        run_check("gap_halt2", 2);

        // Four-entry IMEM: six words offered, only four land.
        b_rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            b_in_valid = 1'b1;
            b_in_data  = 32'h100 + 32'(i);
            tick();
            if (i < 4) begin
                chk("small_we", 32'(b_imem_we), 32'd1);
                chk("small_addr", 32'(b_imem_addr), 32'(i));
                chk("small_data", b_imem_wdata, 32'h100 + 32'(i));
            end else begin
                chk("small_we_lo", 32'(b_imem_we), 32'd0);
                chk("small_ready_lo", 32'(b_in_ready), 32'd0);
            end
        end
        b_in_valid = 1'b0;
        chk("small_words", 32'(b_words_loaded), 32'd4);
        chk("small_core_rst", 32'(b_core_rst), 32'd1);
        chk("small_running", 32'(b_running), 32'd0);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/core_boot_ctrl.md
Name: core_boot_ctrl

Overview:
- Drives the other end of the processor's clk/rst boundary: loads a program image into instruction memory, then owns the core's reset and run window.
- Holds the core in reset while a valid/ready word stream is written into IMEM, then releases reset and counts run cycles.
- Terminates the run on a core halt or on a cycle limit and reports the outcome.
- Sits between the host/stimulus stream and SimpleRISC_Processor plus its IMEM write port.

Parameters:
- ADDR_W, 8, IMEM word-address width; depth is 2**ADDR_W.
- DATA_W, 32, instruction word width.
- RST_HOLD, 4, cycles core_rst stays high after loading completes (must be ≥ 1).
- RUN_LIMIT, 20, maximum run cycles before a timeout (must be ≥ 1, < 2**16).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  program word valid.
- in_data  in  DATA_W  program word.
- in_last  in  1  final word of the image; qualified by in_valid.
- in_ready  out  1  loader can accept a word.
- imem_we  out  1  IMEM write strobe.
- imem_addr  out  ADDR_W  IMEM write address.
- imem_wdata  out  DATA_W  IMEM write data.
- core_rst  out  1  reset to the processor, active-high.
- core_halt  in  1  halt indication from the processor.
- running  out  1  high while the core is released.
- done  out  1  run ended; sticky until rst.
- timeout  out  1  run ended by RUN_LIMIT; sticky until rst.
- cycle_count  out  16  run cycles elapsed.
- words_loaded  out  ADDR_W+1  count of accepted words.

Behaviour:
- Clock/reset: one clock, clk. rst is synchronous and active-high; it is sampled only on the rising edge.
- All outputs are registered.
- Reset values:
  - state = LOAD, in_ready = 1, core_rst = 1.
  - imem_we = 0, imem_addr = 0, imem_wdata = 0.
  - running, done, timeout = 0.
  - cycle_count, words_loaded, hold counter = 0.
- Reset asserted in any state (including mid-load or mid-run) returns everything to the reset values on the next edge. Previously written IMEM contents are not cleared.
- States: LOAD → HOLD → RUN → DONE.
- LOAD:
  - A transfer occurs when in_valid & in_ready are both high.
  - On a transfer: the next cycle has imem_we = 1, imem_addr = write pointer, imem_wdata = in_data. The pointer and words_loaded then increment. Write latency is 1 cycle.
  - imem_we = 0 on any cycle without a transfer.
  - Exit to HOLD when the accepted word has in_last = 1, or when it was written at address 2**ADDR_W-1. At the last address the word is accepted and in_last is ignored. There is no wrap-around.
  - in_ready drops to 0 in the cycle after the exit transfer and stays 0 until rst.
  - in_last without in_valid has no effect.
- HOLD:
  - core_rst = 1 for exactly RST_HOLD cycles.
  - core_rst falls on the edge entering RUN.
- RUN:
  - core_rst = 0, running = 1.
  - cycle_count increments by 1 per cycle, starting at 0 on the first RUN cycle.
  - core_halt = 1 → DONE, timeout = 0.
  - cycle_count == RUN_LIMIT-1 with no halt → DONE, timeout = 1.
  - core_halt and the limit in the same cycle: halt wins, timeout = 0.
  - core_halt is ignored outside RUN.
- DONE:
  - core_rst = 1, running = 0, done = 1.
  - cycle_count frozen at its final value.
  - State is held until rst.
- Widths: cycle_count saturates at 16'hFFFF (unreachable given the RUN_LIMIT bound). words_loaded max is 2**ADDR_W.

Decomposition:
- Shared package core_boot_pkg:
  - state enum with encodings LOAD=0, HOLD=1, RUN=2, DONE=3.
  - default width constants ADDR_W / DATA_W, shared with the processor's IMEM.
- One natural sub-module: boot_run_timer. It holds the HOLD down-counter and the RUN cycle counter, with load/enable/expire outputs.
- The FSM and IMEM write path stay in core_boot_ctrl.

Test Plan:
- Reset, then 3 words 0x11,0x22,0x33 (last on 0x33) with continuous valid → imem_we pulses at addr 0,1,2 with matching data; words_loaded = 3; in_ready = 0 afterwards; core_rst high for 4 cycles, then low.
- Load 1 word, core_halt asserted on RUN cycle 5 → done = 1, timeout = 0, cycle_count = 5, core_rst = 1, running = 0.
- Load 1 word, core_halt never asserted → DONE after 20 RUN cycles with timeout = 1, cycle_count = 19.
- Halt asserted exactly on cycle 19 → timeout = 0, done = 1.
- ADDR_W = 2, stream 6 words with no last → only 4 accepted (addr 0–3), then HOLD; in_ready = 0 for words 5–6.
- rst pulsed mid-load after 2 words and again mid-RUN → state LOAD, all outputs at their reset values next cycle; reload from addr 0 works.
- in_valid toggling (gaps), core_halt pulses during LOAD/HOLD → no spurious writes, halt ignored.
